// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline controller: FSM states, cp0 bubble codes
// and the writeback select that marks a load.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MDU  = 2'd1,
    ST_EXC1 = 2'd2,
    ST_EXC2 = 2'd3
  } state_t;

  localparam logic [1:0] CP0B_NONE = 2'd0;
  localparam logic [1:0] CP0B_CLR  = 2'd3;
  localparam logic [1:0] WB_LOAD   = 2'd1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bus between the pipeline datapath (master) and pipe_ctrl (slave):
// ID/EX/MEM hazard info, mult/div and cp0 events in; stall/flush controls out.
interface pipe_ctrl_if;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt;
  logic [4:0] ex_rw;
  logic       ex_regWr;
  logic [1:0] ex_memtoreg;
  logic [4:0] mem_rw;
  logic       mem_regWr;
  logic       id_mdu_start, id_is_div, id_reads_hl;
  logic       cp0_exc, cp0_eret;
  logic       stall_if, stall_id, bubble_ex;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
  logic       pc_sel_exc, mdu_busy, mdu_abort;
  logic [1:0] cp0bubble;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rw, ex_regWr, ex_memtoreg,
           mem_rw, mem_regWr, id_mdu_start, id_is_div, id_reads_hl,
           cp0_exc, cp0_eret,
    input  stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex,
           flush_ex_mem, pc_sel_exc, mdu_busy, mdu_abort, cp0bubble
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rw, ex_regWr, ex_memtoreg,
           mem_rw, mem_regWr, id_mdu_start, id_is_div, id_reads_hl,
           cp0_exc, cp0_eret,
    output stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex,
           flush_ex_mem, pc_sel_exc, mdu_busy, mdu_abort, cp0bubble
  );
endinterface

// File: rtl/hazard_det.sv
// Combinational RAW hazard detector for the ID stage. With PIPE_CTRL_FWD_EN
// defined only load-use stalls; otherwise any pending EX/MEM write stalls.
module hazard_det
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic [4:0] ex_rw,
  input  logic       ex_regWr,
  input  logic [1:0] ex_memtoreg,
  input  logic [4:0] mem_rw,
  input  logic       mem_regWr,
  output logic       hz
);

  logic ex_match, mem_match, load_use;

  // r0 is never a real dependency
  assign ex_match  = ex_regWr && (ex_rw != 5'd0) &&
                     ((uses_rs && rs == ex_rw) || (uses_rt && rt == ex_rw));
  assign mem_match = mem_regWr && (mem_rw != 5'd0) &&
                     ((uses_rs && rs == mem_rw) || (uses_rt && rt == mem_rw));
  assign load_use  = ex_match && (ex_memtoreg == WB_LOAD);

`ifdef PIPE_CTRL_FWD_EN
  logic unused_mem;
  assign unused_mem = mem_match;
  assign hz = load_use;
`else
  assign hz = load_use | ex_match | mem_match;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: hazard stalls, HI/LO unit occupancy and the two-cycle
// exception/eret flush sequence. Optional macro: PIPE_CTRL_FWD_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

  state_t     state, state_nxt;
  logic [5:0] mdu_cnt, cnt_nxt;
  logic       hz, evt;
  logic       stall, busy, abort, flush_all, flush_fe, pc_exc;
  logic [1:0] cp0b;

  hazard_det u_hz (
    .rs          (bus.id_rs),
    .rt          (bus.id_rt),
    .uses_rs     (bus.id_uses_rs),
    .uses_rt     (bus.id_uses_rt),
    .ex_rw       (bus.ex_rw),
    .ex_regWr    (bus.ex_regWr),
    .ex_memtoreg (bus.ex_memtoreg),
    .mem_rw      (bus.mem_rw),
    .mem_regWr   (bus.mem_regWr),
    .hz          (hz)
  );

  assign evt = bus.cp0_exc | bus.cp0_eret;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      mdu_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = mdu_cnt;
    case (state)
      ST_RUN: begin
        if (evt) begin
          state_nxt = ST_EXC1;
        end else if (bus.id_mdu_start && !hz) begin
          state_nxt = ST_MDU;
          cnt_nxt   = bus.id_is_div ? DIV_CNT : MULT_CNT;
        end
      end
      ST_MDU: begin
        if (evt) begin
          state_nxt = ST_EXC1;
          cnt_nxt   = '0;
        end else if (mdu_cnt <= 6'd1) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = mdu_cnt - 6'd1;
        end
      end
      ST_EXC1: state_nxt = ST_EXC2;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Exception beats MDU wait beats hazard; everything is masked during reset.
  always_comb begin
    stall     = 1'b0;
    busy      = 1'b0;
    abort     = 1'b0;
    flush_all = 1'b0;
    flush_fe  = 1'b0;
    pc_exc    = 1'b0;
    cp0b      = CP0B_NONE;
    if (rst_n) begin
      case (state)
        ST_RUN: stall = !evt && hz;
        ST_MDU: begin
          busy  = 1'b1;
          abort = evt;
          stall = !evt && (hz || bus.id_reads_hl || bus.id_mdu_start);
        end
        ST_EXC1: begin
          flush_all = 1'b1;
          flush_fe  = 1'b1;
          pc_exc    = 1'b1;
          cp0b      = CP0B_CLR;
        end
        default: flush_fe = 1'b1;
      endcase
    end
  end

  assign bus.stall_if     = stall;
  assign bus.stall_id     = stall;
  assign bus.bubble_ex    = stall;
  assign bus.flush_if_id  = flush_fe;
  assign bus.flush_id_ex  = flush_all;
  assign bus.flush_ex_mem = flush_all;
  assign bus.pc_sel_exc   = pc_exc;
  assign bus.mdu_busy     = busy;
  assign bus.mdu_abort    = abort;
  assign bus.cp0bubble    = cp0b;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4, giving the multiply occupancy of the HI/LO unit in cycles (legal range 1..63).
REQ-002 SHALL have parameter DIV_LAT, default 32, giving the divide occupancy in cycles (legal range 1..63).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports id_rs and id_rt, inputs, 5 bits each: the source registers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs and id_uses_rt, inputs, 1 bit each: the ID instruction reads that source.
REQ-007 SHALL have ports ex_rw, ex_regWr and ex_memtoreg, inputs, 5/1/2 bits: destination register, write enable and writeback select of the instruction in EX; a writeback select of 2'd1 marks a load.
REQ-008 SHALL have ports mem_rw and mem_regWr, inputs, 5/1 bits: destination register and write enable of the instruction in MEM.
REQ-009 SHALL have ports id_mdu_start, id_is_div and id_reads_hl, inputs, 1 bit each: the ID instruction is a mult/div, the mult/div is a divide, and the ID instruction is mfhi/mflo.
REQ-010 SHALL have ports cp0_exc and cp0_eret, inputs, 1 bit each: an exception or an eret is signalled from MEM.
REQ-011 SHALL have outputs stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, flush_ex_mem, pc_sel_exc, mdu_busy and mdu_abort, 1 bit each.
REQ-012 SHALL have output cp0bubble, 2 bits: the cp0 bubble code consumed by the MEM/WR register, where 2'd3 clears the cp0 operation being written back.

Function
REQ-013 SHALL implement the states RUN, MDU, EXC1 and EXC2, held in a 2-bit state register, together with a 6-bit down-counter mdu_cnt.
REQ-014 SHALL detect a hazard (hz) when the ID instruction reads a source that equals ex_rw, with ex_regWr=1, ex_memtoreg=2'd1 and ex_rw!=0.
REQ-015 SHALL, when hz is true in RUN or MDU, assert stall_if, stall_id and bubble_ex combinationally in the same cycle.
REQ-016 SHALL, in RUN, move to MDU when id_mdu_start=1 with no stall, no cp0_exc and no cp0_eret, loading mdu_cnt with DIV_LAT if id_is_div=1 and with MULT_LAT otherwise.
REQ-017 SHALL, in MDU, assert mdu_busy and decrement mdu_cnt by one each cycle; when mdu_cnt=1 the state returns to RUN and mdu_cnt becomes 0.
REQ-018 SHALL, in MDU, when id_reads_hl=1 or id_mdu_start=1, assert stall_if, stall_id and bubble_ex.
REQ-019 SHALL, in RUN or MDU, move to EXC1 when cp0_exc=1 or cp0_eret=1; when this happens in MDU, mdu_abort SHALL pulse for that one cycle and mdu_cnt SHALL clear to 0.
REQ-020 SHALL, in EXC1, assert flush_if_id, flush_id_ex, flush_ex_mem and pc_sel_exc, drive cp0bubble=2'd3, and then move to EXC2.
REQ-021 SHALL, in EXC2, assert flush_if_id only, drive cp0bubble=2'd0, and then move to RUN.
REQ-022 SHALL ignore cp0_exc, cp0_eret, id_mdu_start and hz while in EXC1 or EXC2; in these states the stall outputs are 0.
REQ-023 SHALL apply the priority exception > MDU wait > hazard when several events occur in the same cycle; the flush outputs win over the stall outputs.
REQ-024 SHALL drive cp0bubble=2'd0 in every state other than EXC1.

Reset
REQ-025 SHALL, on any rising clk edge with rst_n=0, set the state to RUN and mdu_cnt to 0.
REQ-026 SHALL force all outputs to 0 while rst_n=0, including when reset is applied mid-MDU or mid-EXC; mdu_abort is not pulsed in that case.

Configuration
REQ-027 SHALL, when PIPE_CTRL_FWD_EN is defined, assume full EX/MEM forwarding and stall only for the load-use hazard defined in REQ-014.
REQ-028 SHALL, when PIPE_CTRL_FWD_EN is undefined, also set hz for any ID source that matches ex_rw with ex_regWr=1, or matches mem_rw with mem_regWr=1, with the matching rw!=0.

Structure
REQ-029 SHALL take the state encodings, the cp0bubble codes (2'd0 for none, 2'd3 for clear) and the load writeback code 2'd1 from the shared package pipe_pkg.
REQ-030 SHALL place the hazard comparator in the sub-module hazard_det, which is purely combinational and includes the PIPE_CTRL_FWD_EN logic; the FSM and counter stay in pipe_ctrl.

Verification
REQ-031 SHALL cover a load-use case: ex_rw=5, ex_regWr=1, ex_memtoreg=1, id_rs=5, id_uses_rs=1 -> stall_if, stall_id and bubble_ex are 1 for exactly 1 cycle; with ex_rw=0 -> no stall.
REQ-032 SHALL cover a multiply occupancy case: mult issued, then mfhi in ID on the next cycle -> mdu_busy high for 4 cycles, mfhi stalled for 4 cycles, released in the cycle after mdu_busy falls.
REQ-033 SHALL cover a divide case: div issued -> mdu_busy is high for exactly 32 cycles, with no stall unless id_reads_hl=1 or id_mdu_start=1.
REQ-034 SHALL cover an exception during a divide: cp0_exc at MDU cycle 10 -> mdu_abort pulses once, EXC1 has all flushes, pc_sel_exc and cp0bubble=3, EXC2 has flush_if_id only, then RUN.
REQ-035 SHALL cover simultaneous events: cp0_eret, hz and id_mdu_start in the same RUN cycle -> EXC1 is entered, no stall is asserted, and MDU is not entered.
REQ-036 SHALL cover the configuration option: without PIPE_CTRL_FWD_EN, mem_rw=7, mem_regWr=1, id_rt=7, id_uses_rt=1 -> 1-cycle stall; with PIPE_CTRL_FWD_EN -> no stall.
